// File: rtl/mudi_unit.sv
// mudi_unit: multiply/divide unit for the E stage of the pipelined MIPS core.
// It owns HI/LO, runs mult/multu/div/divu with a fixed latency, and writes
// HI/LO directly for mthi/mtlo. It also raises the D-stage stall request.
//
// Optional feature: define MUDI_CANCEL_EN to add the `cancel` input. A cancel
// flushes an in-flight operation, and HI/LO keep their previous values.
//
// Ports:
//   clk        core clock, rising edge
//   reset_n    asynchronous active-low reset
//   isStart    E-stage instruction is mult/multu/div/divu/mthi/mtlo
//   mudiOp     000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo
//   rsData     rs operand (multiplicand / dividend / mthi-mtlo source)
//   rtData     rt operand (multiplier / divisor)
//   MUDI_sel   read select: 0 LO, 1 HI
//   D_useMudi  D-stage instruction uses the unit
//   cancel     (MUDI_CANCEL_EN only) flush the in-flight operation
//   busy       an operation is in flight
//   stallReq   stall D/F and insert a bubble into E
//   readData   selected HI or LO
//   hiOut      committed HI
//   loOut      committed LO
//
// State   | meaning
// IDLE    | count == 0, accepts a new operation or mthi/mtlo
// BUSY    | count != 0, pending result commits on the count == 1 edge
module mudi_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        isStart,
  input  logic [2:0]  mudiOp,
  input  logic [31:0] rsData,
  input  logic [31:0] rtData,
  input  logic        MUDI_sel,
  input  logic        D_useMudi,
`ifdef MUDI_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic        stallReq,
  output logic [31:0] readData,
  output logic [31:0] hiOut,
  output logic [31:0] loOut
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [3:0]  count;
  logic [31:0] hiReg, loReg;
  logic [31:0] pendHi, pendLo;
  logic        pendValid;
  logic        cancelHit;

  logic [63:0] prodSigned, prodUnsigned;
  logic [31:0] quotSigned, remSigned, quotUnsigned, remUnsigned;

`ifdef MUDI_CANCEL_EN
  assign cancelHit = cancel;
`else
  assign cancelHit = 1'b0;
`endif

  always_comb begin
    prodSigned   = 64'($signed({{32{rsData[31]}}, rsData}) * $signed({{32{rtData[31]}}, rtData}));
    prodUnsigned = {32'd0, rsData} * {32'd0, rtData};
    quotSigned   = '0;
    remSigned    = '0;
    quotUnsigned = '0;
    remUnsigned  = '0;
    // A zero divisor never commits, so the quotient and remainder are don't-care.
    if (rtData != 32'd0) begin
      // SV signed division truncates toward zero, and the remainder follows the dividend's sign.
      quotSigned   = 32'($signed(rsData) / $signed(rtData));
      remSigned    = 32'($signed(rsData) % $signed(rtData));
      quotUnsigned = rsData / rtData;
      remUnsigned  = rsData % rtData;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      hiReg     <= '0;
      loReg     <= '0;
      pendHi    <= '0;
      pendLo    <= '0;
      pendValid <= 1'b0;
    end else if (cancelHit) begin
      count     <= '0;
      pendHi    <= '0;
      pendLo    <= '0;
      pendValid <= 1'b0;
    end else if (count != 4'd0) begin
      if (count == 4'd1) begin
        if (pendValid) begin
          hiReg <= pendHi;
          loReg <= pendLo;
        end
        pendValid <= 1'b0;
      end
      count <= count - 4'd1;
    end else if (isStart) begin
      unique case (mudiOp)
        OP_MULT: begin
          {pendHi, pendLo} <= prodSigned;
          pendValid        <= 1'b1;
          count            <= 4'(MULT_CYCLES);
        end
        OP_MULTU: begin
          {pendHi, pendLo} <= prodUnsigned;
          pendValid        <= 1'b1;
          count            <= 4'(MULT_CYCLES);
        end
        OP_DIV: begin
          pendLo    <= quotSigned;
          pendHi    <= remSigned;
          pendValid <= (rtData != 32'd0);
          count     <= 4'(DIV_CYCLES);
        end
        OP_DIVU: begin
          pendLo    <= quotUnsigned;
          pendHi    <= remUnsigned;
          pendValid <= (rtData != 32'd0);
          count     <= 4'(DIV_CYCLES);
        end
        OP_MTHI: hiReg <= rsData;
        OP_MTLO: loReg <= rsData;
        default: ;
      endcase
    end
  end

  assign busy     = (count != 4'd0);
  // The start term covers the cycle before busy rises.
  assign stallReq = D_useMudi & (busy | (isStart & ~mudiOp[2]));
  assign readData = MUDI_sel ? hiReg : loReg;
  assign hiOut    = hiReg;
  assign loOut    = loReg;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset_n && isStart && busy)
      $display("mudi_unit warning: isStart while busy ignored at %0t", $time);
  end
`endif

endmodule
